// File: rtl/multdiv_ctrl.sv
// Sequencer between the pipeline and the shared multicycle multiply/divide unit:
// latches a request, starts the unit, stalls until done or timeout, then writes back.
module multdiv_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_mult,
    input  logic        ctrl_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  dest_reg,
    output logic        unit_start,
    output logic        unit_sel,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        unit_abort,
    input  logic        unit_done,
    input  logic [31:0] unit_result,
    input  logic        unit_exception,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [4:0]  result_reg,
    output logic        exception
);
    // state     | meaning
    // S_IDLE    | waiting for a ctrl_mult/ctrl_div request
    // S_ISSUE   | one-cycle unit_start, wait counter cleared
    // S_WAIT    | unit busy; counting toward the timeout
    // S_WB      | one-cycle result_valid strobe
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic [4:0]    dest_q;
    logic          req, div_zero, timeout_hit;

    assign req      = ctrl_mult | ctrl_div;
    assign div_zero = !ctrl_mult && (operand_b == 32'd0);

    always_comb begin
        next_state   = state;
        unit_start   = 1'b0;
        result_valid = 1'b0;
        stall        = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    stall      = 1'b1;
                    next_state = div_zero ? S_WB : S_ISSUE;
                end
            end
            S_ISSUE: begin
                unit_start = 1'b1;
                stall      = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                stall = 1'b1;
                if (unit_done) begin
                    next_state = S_WB;
                end else if (cnt == LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = S_WB;
                end
            end
            S_WB: begin
                result_valid = 1'b1;
                next_state   = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        // While reset is held the pipeline and unit see a quiescent controller.
        if (!reset) begin
            unit_start   = 1'b0;
            result_valid = 1'b0;
            stall        = 1'b0;
        end
    end

    assign unit_abort = !reset || timeout_hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            unit_sel   <= 1'b0;
            unit_a     <= 32'd0;
            unit_b     <= 32'd0;
            dest_q     <= 5'd0;
            result     <= 32'd0;
            result_reg <= 5'd0;
            exception  <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        unit_sel <= !ctrl_mult;
                        unit_a   <= operand_a;
                        unit_b   <= operand_b;
                        dest_q   <= dest_reg;
                        if (div_zero) begin
                            result     <= 32'd0;
                            exception  <= 1'b1;
                            result_reg <= dest_reg;
                        end
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (unit_done) begin
                        result     <= unit_result;
                        exception  <= unit_exception;
                        result_reg <= dest_q;
                    end else if (cnt == LAST) begin
                        result     <= 32'd0;
                        exception  <= 1'b1;
                        result_reg <= dest_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: behavioural unit, per-cycle scoreboard
// driven by request timing, and directed scenarios with literal expectations.
module tb_multdiv_ctrl;
    localparam int TIMEOUT = 40;

    logic        clk = 1'b0, reset = 1'b0, ctrl_mult = 1'b0, ctrl_div = 1'b0;
    logic [31:0] operand_a = 32'd0, operand_b = 32'd0;
    logic [4:0]  dest_reg = 5'd0;
    logic        unit_start, unit_sel, unit_abort;
    logic [31:0] unit_a, unit_b;
    logic        unit_done = 1'b0, unit_exception = 1'b0;
    logic [31:0] unit_result = 32'd0;
    logic        stall, result_valid, exception;
    logic [31:0] result;
    logic [4:0]  result_reg;

    int n_cmp = 0, n_err = 0, cyc = 0;

    multdiv_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
        .operand_a(operand_a), .operand_b(operand_b), .dest_reg(dest_reg),
        .unit_start(unit_start), .unit_sel(unit_sel), .unit_a(unit_a), .unit_b(unit_b),
        .unit_abort(unit_abort), .unit_done(unit_done), .unit_result(unit_result),
        .unit_exception(unit_exception), .stall(stall), .result_valid(result_valid),
        .result(result), .result_reg(result_reg), .exception(exception)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic of the unit: {exception, result}.
    function automatic logic [32:0] unit_op(logic is_div, logic [31:0] a, logic [31:0] b);
        longint p;
        if (!is_div) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return {(p > 64'sd2147483647) || (p < -64'sd2147483648), p[31:0]};
        end
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        return {1'b0, 32'($signed(a) / $signed(b))};
    endfunction

    // Behavioural multicycle unit: done unit_lat cycles after the start cycle.
    int          unit_lat = 4;
    int          done_cyc = -1;
    logic [32:0] u_out = 33'd0;
    initial forever begin
        @(negedge clk);
        if (unit_start === 1'b1) begin
            done_cyc = cyc + unit_lat;
            u_out    = unit_op(unit_sel, unit_a, unit_b);
        end
        @(posedge clk);
        #1;
        unit_done      = (cyc == done_cyc);
        unit_result    = unit_done ? u_out[31:0] : 32'hDEAD_BEEF;
        unit_exception = unit_done ? u_out[32] : 1'b1;
    end

    // Scoreboard: a request fixes the cycles of start, abort and valid.
    logic        busy = 1'b0, prev_rst = 1'b0, e_sel = 1'b0;
    int          s_cyc = -1, v_cyc = -1, a_cyc = -1, req_cyc = 0;
    logic [31:0] e_a = 0, e_b = 0, e_res = 0, h_res = 0;
    logic [4:0]  e_tag = 0, h_tag = 0;
    logic        e_exc = 0, h_exc = 0;
    int          n_valid = 0, n_start = 0, n_abort = 0, n_stall = 0;
    int          last_valid_cyc = 0, last_abort_cyc = 0, last_req_cyc = 0;
    logic [31:0] obs_res = 0;
    logic [4:0]  obs_tag = 0;
    logic        obs_exc = 0;

    always @(negedge clk) begin
        if (cyc >= 2) begin
            if (!reset) begin
                busy = 1'b0;
                chk("abort_in_reset", unit_abort, 1);
                chk("stall_in_reset", stall, 0);
                chk("start_in_reset", unit_start, 0);
                chk("valid_in_reset", result_valid, 0);
            end else begin
                if (!busy && (ctrl_mult || ctrl_div)) begin
                    busy = 1'b1; req_cyc = cyc; last_req_cyc = cyc;
                    e_sel = !ctrl_mult; e_a = operand_a; e_b = operand_b; e_tag = dest_reg;
                    if (e_sel && e_b == 32'd0) begin
                        s_cyc = -1; a_cyc = -1; v_cyc = cyc + 1; e_res = 0; e_exc = 1;
                    end else begin
                        s_cyc = cyc + 1;
                        {e_exc, e_res} = unit_op(e_sel, e_a, e_b);
                        if (unit_lat <= TIMEOUT) begin
                            a_cyc = -1; v_cyc = cyc + 2 + unit_lat;
                        end else begin
                            a_cyc = cyc + 1 + TIMEOUT; v_cyc = cyc + 2 + TIMEOUT;
                            e_res = 0; e_exc = 1;
                        end
                    end
                end
                if (busy && cyc == v_cyc) begin
                    h_res = e_res; h_tag = e_tag; h_exc = e_exc;
                end
                chk("unit_start", unit_start, busy && cyc == s_cyc);
                chk("stall", stall, busy && cyc < v_cyc);
                chk("result_valid", result_valid, busy && cyc == v_cyc);
                chk("unit_abort", unit_abort, busy && cyc == a_cyc);
                if (busy && s_cyc >= 0 && cyc >= s_cyc && cyc < v_cyc) begin
                    chk("unit_sel", unit_sel, e_sel);
                    chk("unit_a", unit_a, e_a);
                    chk("unit_b", unit_b, e_b);
                end
                if (!prev_rst) begin
                    chk("unit_a_after_reset", unit_a, 0);
                    chk("unit_b_after_reset", unit_b, 0);
                    chk("unit_sel_after_reset", unit_sel, 0);
                end
                if (busy && cyc == v_cyc) busy = 1'b0;
                n_valid += int'(result_valid);
                n_start += int'(unit_start);
                n_stall += int'(stall);
                if (unit_abort) begin n_abort++; last_abort_cyc = cyc; end
                if (result_valid) begin
                    last_valid_cyc = cyc; obs_res = result; obs_tag = result_reg; obs_exc = exception;
                end
            end
            chk("result_hold", result, h_res);
            chk("result_reg_hold", result_reg, h_tag);
            chk("exception_hold", exception, h_exc);
            if (!reset) begin h_res = 0; h_tag = 0; h_exc = 0; end
        end
        prev_rst = reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(logic m, logic d, logic [31:0] a, logic [31:0] b, logic [4:0] t);
        ctrl_mult = m; ctrl_div = d; operand_a = a; operand_b = b; dest_reg = t;
        tick();
        ctrl_mult = 0; ctrl_div = 0; operand_a = 32'h5A5A_5A5A; operand_b = 32'd0; dest_reg = 5'd31;
    endtask

    task automatic wait_idle(string name);
        for (int k = 0; k < 300; k++) begin
            if (!busy) break;
            tick();
        end
        n_cmp++;
        if (busy) begin
            n_err++;
            $display("FAIL %s: operation still pending after 300 cycles", name);
        end
    endtask

    int sv, ss, sst, sa;

    initial begin
        reset = 0;
        repeat (3) tick();
        reset = 1;
        tick();

        // Multiply 7 x -3, unit latency 32.
        sv = n_valid; ss = n_start; sst = n_stall;
        unit_lat = 32;
        req(1, 0, 32'd7, 32'hFFFF_FFFD, 5'd9);
        wait_idle("mul_wait");
        chk("t1_result", obs_res, 32'hFFFF_FFEB);
        chk("t1_tag", obs_tag, 9);
        chk("t1_exc", obs_exc, 0);
        chk("t1_valid_pulses", n_valid - sv, 1);
        chk("t1_starts", n_start - ss, 1);
        chk("t1_stall_cycles", n_stall - sst, 34);
        chk("t1_latency", last_valid_cyc - last_req_cyc, 34);

        // Divide by zero, back-to-back with the previous writeback.
        sv = n_valid; ss = n_start;
        req(0, 1, 32'd100, 32'd0, 5'd5);
        wait_idle("dbz_wait");
        chk("t2_result", obs_res, 0);
        chk("t2_exc", obs_exc, 1);
        chk("t2_tag", obs_tag, 5);
        chk("t2_starts", n_start - ss, 0);
        chk("t2_latency", last_valid_cyc - last_req_cyc, 1);

        // Signed divide -100 / 7.
        unit_lat = 6;
        req(0, 1, 32'hFFFF_FF9C, 32'd7, 5'd14);
        wait_idle("div_wait");
        chk("t3_result", obs_res, 32'hFFFF_FFF2);
        chk("t3_exc", obs_exc, 0);

        // Multiply overflow reported by the unit.
        unit_lat = 5;
        req(1, 0, 32'h4000_0000, 32'd4, 5'd3);
        wait_idle("ovf_wait");
        chk("t4_result", obs_res, 0);
        chk("t4_exc", obs_exc, 1);
        chk("t4_tag", obs_tag, 3);

        // Hung unit: abort in the 40th WAIT cycle, then a fresh request.
        sa = n_abort; sv = n_valid;
        unit_lat = 1000;
        req(1, 0, 32'd123, 32'd456, 5'd7);
        wait_idle("hung_wait");
        chk("t5_aborts", n_abort - sa, 1);
        chk("t5_abort_cycle", last_abort_cyc - last_req_cyc, 41);
        chk("t5_valid_cycle", last_valid_cyc - last_req_cyc, 42);
        chk("t5_result", obs_res, 0);
        chk("t5_exc", obs_exc, 1);
        chk("t5_tag", obs_tag, 7);
        unit_lat = 3;
        req(1, 0, 32'd6, 32'd7, 5'd8);
        wait_idle("after_hung_wait");
        chk("t5b_result", obs_res, 32'd42);
        chk("t5b_latency", last_valid_cyc - last_req_cyc, 5);
        chk("t5_valid_pulses", n_valid - sv, 2);

        // Reset in WAIT cycle 10; the late done must be ignored.
        sv = n_valid;
        unit_lat = 32;
        req(1, 0, 32'd11, 32'd13, 5'd20);
        repeat (10) tick();
        reset = 0;
        tick();
        reset = 1;
        repeat (40) tick();
        chk("t6_valid_pulses", n_valid - sv, 0);
        chk("t6_result_cleared", result, 0);
        chk("t6_tag_cleared", result_reg, 0);

        // Both requests together, then a divide request mid-WAIT.
        sv = n_valid; ss = n_start;
        unit_lat = 4;
        req(1, 1, 32'd10, 32'd3, 5'd12);
        repeat (2) tick();
        ctrl_div = 1; operand_b = 32'd0;
        tick();
        ctrl_div = 0;
        wait_idle("both_wait");
        repeat (5) tick();
        chk("t7_result", obs_res, 32'd30);
        chk("t7_tag", obs_tag, 12);
        chk("t7_valid_pulses", n_valid - sv, 1);
        chk("t7_starts", n_start - ss, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
